// File: rtl/counter_nch_pkg.sv
// rtl/counter_nch_pkg.sv - shared encodings for the multi-channel down-counter
package counter_nch_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;
  localparam logic [1:0] MODE_SQUARE  = 2'd2;

  localparam logic [1:0] REG_RELOAD = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_IRQCLR = 2'd2;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_LSB  = 1;
  localparam int CTRL_PRESC_LSB = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_nch_chan.sv
// rtl/counter_nch_chan.sv - one counter channel: prescaler, mode FSM, count and reload
module counter_nch_chan
  import counter_nch_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload_we,
  input  logic             ctrl_we,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] count,
  output logic             cnt_out,
  output logic             irq_set
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [1:0]       mode_q, mode_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             cnt_out_q, cnt_out_d;
  logic             tick, terminal;

  assign tick     = (state_q == RUN) && (pre_q == presc_q);
  // A count of 0 or 1 both end the period, so a zero reload acts like 1.
  assign terminal = tick && (count_q <= CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pre_d     = pre_q;
    cnt_out_d = cnt_out_q;
    reload_d  = reload_we ? wdata : reload_q;
    mode_d    = ctrl_we ? wdata[CTRL_MODE_LSB +: 2] : mode_q;
    presc_d   = ctrl_we ? wdata[CTRL_PRESC_LSB +: PRE_W] : presc_q;

    if (state_q == RUN) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (mode_q == MODE_RELOAD) cnt_out_d = 1'b0;
      if (terminal) begin
        case (mode_q)
          MODE_RELOAD: begin
            count_d   = reload_d;
            cnt_out_d = 1'b1;
          end
          MODE_SQUARE: begin
            count_d   = reload_d;
            cnt_out_d = ~cnt_out_q;
          end
          default: begin
            count_d   = '0;
            cnt_out_d = 1'b1;
            state_d   = DONE;
          end
        endcase
      end else if (tick) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    if (ctrl_we) begin
      if (wdata[CTRL_EN_BIT]) begin
        state_d   = RUN;
        count_d   = reload_d;
        pre_d     = '0;
        cnt_out_d = 1'b0;
      end else begin
        state_d   = IDLE;
        count_d   = count_q;
        pre_d     = pre_q;
        cnt_out_d = cnt_out_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      mode_q    <= '0;
      presc_q   <= '0;
      pre_q     <= '0;
      cnt_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      pre_q     <= pre_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  assign count   = count_q;
  assign cnt_out = cnt_out_q;
  assign irq_set = terminal;

endmodule

// File: rtl/counter_nch.sv
// rtl/counter_nch.sv - N-channel down-counter: write decode, sticky irq, read-back mux
module counter_nch
  import counter_nch_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PRE_W = 8,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [1:0]       reg_sel,
  input  logic [CNT_W-1:0] wdata,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  cnt_out,
  output logic [N_CH-1:0]  irq,
  output logic             irq_any
);

  logic [CNT_W-1:0] count_w [N_CH];
  logic [N_CH-1:0]  irq_set_w;
  logic [N_CH-1:0]  reload_we, ctrl_we, clr_mask;
  logic [N_CH-1:0]  irq_q, irq_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  // Channel selects that match no instance fall through, so out-of-range writes vanish.
  always_comb begin
    reload_we = '0;
    ctrl_we   = '0;
    rd_data_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (we && (ch_sel == CH_W'(i))) begin
        reload_we[i] = (reg_sel == REG_RELOAD);
        ctrl_we[i]   = (reg_sel == REG_CTRL);
      end
      if (rd_ch == CH_W'(i)) rd_data_d = count_w[i];
    end
    clr_mask = (we && (reg_sel == REG_IRQCLR)) ? wdata[N_CH-1:0] : '0;
    irq_d    = (irq_q & ~clr_mask) | irq_set_w;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    counter_nch_chan #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .reload_we (reload_we[g]),
      .ctrl_we   (ctrl_we[g]),
      .wdata     (wdata),
      .count     (count_w[g]),
      .cnt_out   (cnt_out[g]),
      .irq_set   (irq_set_w[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      rd_data_q <= '0;
    end else begin
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign irq     = irq_q;
  assign irq_any = |irq_q;
  assign rd_data = rd_data_q;

endmodule
